// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the data-side memory responder.
// Contents: word_t, the responder FSM state enum, the latency counter width
// and the latched request payload struct.
package cpu_types_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DMEM_LAT_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Request captured in IDLE and held for the whole transaction.
  typedef struct packed {
    logic  we;
    logic  atomic;
    word_t addr;
    word_t data;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_llsc_link.sv
// LL/SC link register: one valid bit plus the linked word index.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   set_i, set_idx_i  LL completes: link to set_idx_i
//   clr_i             SC or matching store completes: drop the link
//   snoop_i/_idx_i    remote write index, checked every cycle
//   query_idx_i       index of the completing access
//   match_o_c         link valid, equals query_idx_i and not snooped this cycle
module llsc_link #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic             clr_i,
  input  logic             snoop_i,
  input  logic [IDX_W-1:0] snoop_idx_i,
  input  logic [IDX_W-1:0] query_idx_i,
  output logic             match_o_c
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             snoop_hit_c;

  // A snoop in the same cycle as the access wins over the link.
  assign snoop_hit_c = snoop_i && (snoop_idx_i == idx_q);
  assign match_o_c   = valid_q && (idx_q == query_idx_i) && !snoop_hit_c;

  // Next link state; a new LL replaces the old link, unless snooped itself.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    if (snoop_hit_c || clr_i) begin
      valid_d = 1'b0;
    end
    if (set_i) begin
      idx_d   = set_idx_i;
      valid_d = !(snoop_i && (snoop_idx_i == set_idx_i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: answers dcache read/write (and LL/SC) requests
// with a one-cycle dhit after LATENCY+1 cycles, backed by a word array.
// Ports:
//   CLK, RST              clock, async active-high reset
//   dmemREN/dmemWEN       read/write request, held until dhit (WEN wins)
//   datomic               REN -> LL, WEN -> SC
//   dmemaddr, dmemstore   byte address, store data
//   snoop_inv/snoop_addr  remote write, invalidates a matching link
//   dhit, dmemload        response strobe and load / SC result
//   sc_fail_cnt           failed SC count, built only with DMEM_RESPONDER_STATS_EN
module dmem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic [15:0] sc_fail_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 29) begin : g_bad_depth
    $error("dmem_responder: DEPTH_LOG2 must be in 1..29");
  end

  dmem_state_t           state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  logic                  dhit_q;
  word_t                 dmemload_q, dmemload_d;
  word_t                 mem_q [DEPTH];

  logic                  do_op_c;
  logic                  link_match_c;
  logic                  link_set_c;
  logic                  link_clr_c;
  logic                  mem_we_c;
  logic                  sc_fail_c;
  logic [DEPTH_LOG2-1:0] req_idx_c;
  logic [DEPTH_LOG2-1:0] snoop_idx_c;
  logic                  unused_c;

  // Word index; byte offset and upper bits alias away.
  assign req_idx_c   = req_q.addr[DEPTH_LOG2+1:2];
  assign snoop_idx_c = snoop_addr[DEPTH_LOG2+1:2];
  assign unused_c    = ^{req_q.addr[31:DEPTH_LOG2+2], req_q.addr[1:0],
                         snoop_addr[31:DEPTH_LOG2+2], snoop_addr[1:0]};

  // FSM next state and per-op control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    do_op_c    = 1'b0;
    dmemload_d = dmemload_q;
    unique case (state_q)
      IDLE: begin
        if (dmemREN || dmemWEN) begin
          req_d   = '{we: dmemWEN, atomic: datomic, addr: dmemaddr, data: dmemstore};
          cnt_d   = DMEM_LAT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!(dmemREN || dmemWEN)) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          do_op_c = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    link_set_c = do_op_c && !req_q.we && req_q.atomic;
    link_clr_c = do_op_c && req_q.we && (req_q.atomic || link_match_c);
    mem_we_c   = do_op_c && req_q.we && (!req_q.atomic || link_match_c);
    sc_fail_c  = do_op_c && req_q.we && req_q.atomic && !link_match_c;

    if (do_op_c && !req_q.we) begin
      dmemload_d = mem_q[req_idx_c];
    end else if (do_op_c && req_q.atomic) begin
      dmemload_d = {31'd0, link_match_c};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      dhit_q     <= 1'b0;
      dmemload_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      dhit_q     <= do_op_c;
      dmemload_q <= dmemload_d;
    end
  end

  // Backing array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      mem_q[req_idx_c] <= req_q.data;
    end
  end

  llsc_link #(
    .IDX_W (DEPTH_LOG2)
  ) u_link (
    .clk_i       (CLK),
    .rst_i       (RST),
    .set_i       (link_set_c),
    .set_idx_i   (req_idx_c),
    .clr_i       (link_clr_c),
    .snoop_i     (snoop_inv),
    .snoop_idx_i (snoop_idx_c),
    .query_idx_i (req_idx_c),
    .match_o_c   (link_match_c)
  );

`ifdef DMEM_RESPONDER_STATS_EN
  logic [15:0] sc_fail_cnt_q, sc_fail_cnt_d;

  // Saturating failed-SC counter.
  assign sc_fail_cnt_d = (sc_fail_c && (sc_fail_cnt_q != 16'hFFFF)) ?
                         sc_fail_cnt_q + 16'd1 : sc_fail_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc_fail_cnt_q <= '0;
    end else begin
      sc_fail_cnt_q <= sc_fail_cnt_d;
    end
  end

  assign sc_fail_cnt = sc_fail_cnt_q;
`else
  logic unused_stats_c;
  assign unused_stats_c = sc_fail_c;
  assign sc_fail_cnt    = '0;
`endif

  assign dhit     = dhit_q;
  assign dmemload = dmemload_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an
// event-level memory / LL-SC model.
module tb_dmem_responder;

  localparam int unsigned LAT = 2;
  localparam int unsigned DL  = 8;
  localparam int unsigned NW  = 1 << DL;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic        snoop_inv = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        dhit;
  logic [31:0] dmemload;
  logic [15:0] sc_fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] m_mem [NW];
  bit          m_lv = 1'b0;
  int          m_la = 0;
  logic [31:0] m_load = '0;
  int          m_scf = 0;

  dmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .datomic    (datomic),
    .dmemaddr   (dmemaddr),
    .dmemstore  (dmemstore),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .dhit       (dhit),
    .dmemload   (dmemload),
    .sc_fail_cnt(sc_fail_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'(NW - 1));
  endfunction

  function automatic logic [31:0] exp_scf();
`ifdef DMEM_RESPONDER_STATS_EN
    return 32'(m_scf);
`else
    return 32'd0;
`endif
  endfunction

  // smode: 0 no snoop, 1 random snoops, 2 snoop of addr itself in cycle 1.
  task automatic do_txn(input bit re, input bit we, input bit at,
                        input logic [31:0] addr, input logic [31:0] data, input int smode);
    int idx = idx_of(addr);
    bit s;
    int sidx;
    bit ok;
    @(negedge CLK);
    dmemREN = re; dmemWEN = we; datomic = at; dmemaddr = addr; dmemstore = data;
    for (int c = 0; c <= int'(LAT); c++) begin
      if (c > 0) begin
        @(negedge CLK);
        check_eq("dhit_early", 32'(dhit), 32'd0);
      end
      s = 1'b0;
      sidx = 0;
      if (smode == 1 && $urandom_range(0, 3) == 0) begin
        s = 1'b1;
        sidx = int'($urandom_range(0, 7));
        snoop_addr = ($urandom & 32'hFFFF_FC00) | (32'(sidx) << 2) | ($urandom & 32'h3);
      end else if (smode == 2 && c == 1) begin
        s = 1'b1;
        sidx = idx;
        snoop_addr = addr;
      end
      snoop_inv = s;
      // Snoops seen before or at the completing edge invalidate first.
      if (s && m_lv && sidx == m_la) m_lv = 1'b0;
      if (c == int'(LAT)) begin
        if (we) begin
          if (at) begin
            ok = m_lv && (m_la == idx);
            if (ok) m_mem[idx] = data;
            else if (m_scf < 65535) m_scf++;
            m_load = {31'd0, ok};
            m_lv = 1'b0;
          end else begin
            m_mem[idx] = data;
            if (m_lv && m_la == idx) m_lv = 1'b0;
          end
        end else begin
          m_load = m_mem[idx];
          if (at) begin
            m_lv = 1'b1;
            m_la = idx;
            if (s && sidx == idx) m_lv = 1'b0;
          end
        end
      end
    end
    @(negedge CLK);
    check_eq("dhit_latency", 32'(dhit), 32'd1);
    check_eq("dmemload", dmemload, m_load);
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0; snoop_inv = 1'b0;
    @(negedge CLK);
    check_eq("dhit_one_cycle", 32'(dhit), 32'd0);
    check_eq("dmemload_hold", dmemload, m_load);
    check_eq("sc_fail_cnt", 32'(sc_fail_cnt), exp_scf());
  endtask

  // Write dropped in WAIT cycle k (1..LAT): nothing happens.
  task automatic flush_txn(input logic [31:0] addr, input logic [31:0] data, input int k);
    @(negedge CLK);
    dmemWEN = 1'b1; datomic = 1'b0; dmemaddr = addr; dmemstore = data;
    repeat (k) @(negedge CLK);
    dmemWEN = 1'b0;
    repeat (LAT + 2) begin
      @(negedge CLK);
      check_eq("flush_no_dhit", 32'(dhit), 32'd0);
    end
    check_eq("flush_load_hold", dmemload, m_load);
  endtask

  // Reset pulsed in the first WAIT cycle of a store.
  task automatic reset_mid(input logic [31:0] addr, input logic [31:0] data);
    @(negedge CLK);
    dmemWEN = 1'b1; dmemaddr = addr; dmemstore = data;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("rst_mid_dhit", 32'(dhit), 32'd0);
    check_eq("rst_mid_load", dmemload, 32'd0);
    check_eq("rst_mid_scf", 32'(sc_fail_cnt), 32'd0);
    dmemWEN = 1'b0;
    RST = 1'b0;
    m_lv = 1'b0; m_load = '0; m_scf = 0;
    repeat (LAT + 2) begin
      @(negedge CLK);
      check_eq("rst_mid_no_dhit", 32'(dhit), 32'd0);
    end
  endtask

  initial begin
    int k;
    int ix;
    logic [31:0] a;
    repeat (2) @(negedge CLK);
    check_eq("rst_dhit", 32'(dhit), 32'd0);
    check_eq("rst_dmemload", dmemload, 32'd0);
    check_eq("rst_sc_fail_cnt", 32'(sc_fail_cnt), 32'd0);
    RST = 1'b0;

    // Fill the array so every word has a known value.
    for (int i = 0; i < int'(NW); i++) do_txn(1'b0, 1'b1, 1'b0, 32'(i) << 2, $urandom, 0);

    // Store, LL, successful SC, load back.
    do_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEAD, 0);
    do_txn(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 0);
    check_eq("ll_data", dmemload, 32'hDEAD);
    do_txn(1'b0, 1'b1, 1'b1, 32'h40, 32'h1234, 0);
    check_eq("sc_success", dmemload, 32'd1);
    do_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 0);
    check_eq("load_after_sc", dmemload, 32'h1234);

    // LL, snoop of the same word during WAIT, SC fails.
    do_txn(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 0);
    do_txn(1'b0, 1'b1, 1'b1, 32'h40, 32'hBEEF, 2);
    check_eq("sc_snooped_fail", dmemload, 32'd0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 0);
    check_eq("snooped_word_kept", dmemload, 32'h1234);

    // Held REN: dhit in cycles LAT+1 and 2*LAT+3, request re-accepted right after RESP.
    @(negedge CLK);
    dmemREN = 1'b1; dmemaddr = 32'h8;
    for (int c = 1; c <= 2 * int'(LAT) + 3; c++) begin
      @(negedge CLK);
      check_eq($sformatf("b2b_dhit_c%0d", c), 32'(dhit),
               32'((c == int'(LAT) + 1) || (c == 2 * int'(LAT) + 3)));
    end
    m_load = m_mem[2];
    check_eq("b2b_data", dmemload, m_load);
    dmemREN = 1'b0;
    @(negedge CLK);

    // Flush of a write leaves memory alone.
    flush_txn(32'h10, 32'h55, 1);
    do_txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 0);

    // REN&WEN: write wins, 0x404 aliases word 1.
    do_txn(1'b1, 1'b1, 1'b0, 32'h404, 32'hA5A5_0001, 0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 0);
    check_eq("alias_load", dmemload, 32'hA5A5_0001);

    // Reset mid-transaction: no write, link dropped, SC then fails.
    do_txn(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 0);
    reset_mid(32'h80, 32'h777);
    do_txn(1'b0, 1'b1, 1'b1, 32'h80, 32'h999, 0);
    check_eq("sc_after_reset", dmemload, 32'd0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 0);

    // Random mix over a small index window to exercise links and snoops.
    for (int n = 0; n < 400; n++) begin
      ix = int'($urandom_range(0, 7));
      a = ($urandom & 32'hFFFF_FC00) | (32'(ix) << 2) | ($urandom & 32'h3);
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1:    do_txn(1'b1, 1'b0, 1'b0, a, $urandom, 1);
        2:       do_txn(1'b0, 1'b1, 1'b0, a, $urandom, 1);
        3, 4, 5: do_txn(1'b1, 1'b0, 1'b1, a, $urandom, 1);
        6, 7:    do_txn(1'b0, 1'b1, 1'b1, a, $urandom, 1);
        8:       do_txn(1'b1, 1'b1, $urandom_range(0, 1) == 1, a, $urandom, 1);
        default: flush_txn(a, $urandom, int'($urandom_range(1, LAT)));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
